// File: rtl/video_pkg.sv
// Shared video timing constants and the RGB332 -> RGB888 pixel expansion.
package video_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int unsigned ADDR_W   = 19;

   // Replicate the high bits of each channel so full-scale codes map to 0xFF.
   function automatic logic [23:0] rgb332_to_888(input logic [7:0] d);
      return {d[7:5], d[7:5], d[7:6],
              d[4:2], d[4:2], d[4:3],
              d[1:0], d[1:0], d[1:0], d[1:0]};
   endfunction

endpackage

// File: rtl/frame_scanout_if.sv
// Frame-buffer read port plus the pixel stream toward the display encoder.
interface frame_scanout_if;

   logic [video_pkg::ADDR_W-1:0] rdaddress;
   logic [7:0]                   read_data;
   logic [23:0]                  rgb;
   logic                         de;
   logic                         hsync;
   logic                         vsync;
   logic                         frame_start;
   logic                         vblank;

   modport master (
      output rdaddress, rgb, de, hsync, vsync, frame_start, vblank,
      input  read_data
   );

   modport slave (
      input  rdaddress, rgb, de, hsync, vsync, frame_start, vblank,
      output read_data
   );

endinterface

// File: rtl/video_timing.sv
// Stage-0 raster counters and the visible/sync/first-pixel flags derived from them.
module video_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned HW       = 10,
   parameter int unsigned VW       = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          visible,
   output logic          hs_n,
   output logic          vs_n,
   output logic          first,
   output logic          vblank
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Horizontal counter wraps each line; vertical counter advances on that wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == HW'(H_TOTAL - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Position decodes; syncs are active-low.
   always_comb begin
      visible = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
      hs_n    = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                  (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
      vs_n    = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                  (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
      first   = (h_cnt == '0) && (v_cnt == '0);
      vblank  = (v_cnt >= VW'(V_ACTIVE));
   end

endmodule

// File: rtl/frame_scanout.sv
// Scanout engine: raster timing, linear buffer addressing and a 2-stage
// pipeline that lines the sync/enable flags up with the registered read data.
module frame_scanout #(
   parameter int unsigned H_ACTIVE = video_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = video_pkg::H_FP,
   parameter int unsigned H_SYNC   = video_pkg::H_SYNC,
   parameter int unsigned H_BP     = video_pkg::H_BP,
   parameter int unsigned V_ACTIVE = video_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = video_pkg::V_FP,
   parameter int unsigned V_SYNC   = video_pkg::V_SYNC,
   parameter int unsigned V_BP     = video_pkg::V_BP
) (
   input  logic            clk,
   input  logic            reset_n,
   frame_scanout_if.master bus
);

   import video_pkg::*;

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   logic [HW-1:0]     h_cnt;
   logic [VW-1:0]     v_cnt;
   logic              visible, hs_n, vs_n, first, vblank;
   logic [ADDR_W-1:0] pix_cnt, pix_next;
   logic              line_end, frame_end, pix_inc;
   logic              de1, hs1, vs1, fs1;
   logic [23:0]       rgb_q;
   logic              de_q, hsync_q, vsync_q, fs_q;

   video_timing #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .HW       (HW),       .VW   (VW)
   ) u_timing (
      .clk     (clk),
      .reset_n (reset_n),
      .h_cnt   (h_cnt),
      .v_cnt   (v_cnt),
      .visible (visible),
      .hs_n    (hs_n),
      .vs_n    (vs_n),
      .first   (first),
      .vblank  (vblank)
   );

   // Address steps only into a following visible pixel, so it holds the last
   // visible address through blanking and never runs past the final pixel.
   always_comb begin
      pix_next  = pix_cnt;
      line_end  = (h_cnt == HW'(H_TOTAL - 1));
      frame_end = line_end && (v_cnt == VW'(V_TOTAL - 1));
      pix_inc   = (visible && (h_cnt != HW'(H_ACTIVE - 1))) ||
                  (line_end && (v_cnt < VW'(V_ACTIVE - 1)));
      if (frame_end) begin
         pix_next = '0;
      end else if (pix_inc) begin
         pix_next = pix_cnt + 1'b1;
      end
   end

   // Linear pixel address register, driven straight onto the buffer port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_cnt <= '0;
      end else begin
         pix_cnt <= pix_next;
      end
   end

   // Stage 1: delay flags to line up with read_data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de1 <= 1'b0;
         hs1 <= 1'b1;
         vs1 <= 1'b1;
         fs1 <= 1'b0;
      end else begin
         de1 <= visible;
         hs1 <= hs_n;
         vs1 <= vs_n;
         fs1 <= first;
      end
   end

   // Stage 2: output registers, blanking forces black.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q   <= '0;
         de_q    <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         rgb_q   <= de1 ? rgb332_to_888(bus.read_data) : 24'h000000;
         de_q    <= de1;
         hsync_q <= hs1;
         vsync_q <= vs1;
         fs_q    <= fs1;
      end
   end

   assign bus.rdaddress   = pix_cnt;
   assign bus.rgb         = rgb_q;
   assign bus.de          = de_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.frame_start = fs_q;
   assign bus.vblank      = vblank;

endmodule

// File: doc/frame_scanout.md
# frame_scanout

Video scanout engine that reads the 8-bit RGB332 frame buffer and drives a 640x480@60 pixel stream. It generates raster timing and the buffer read address, absorbs the buffer's one-cycle registered read latency, and expands each pixel to 24-bit RGB. It sits between the frame buffer's read port and the HDMI/VGA encoder, in the pixel-clock domain.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (total 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (total 525)
- ADDR_W, 19, frame buffer address width
- clk  in  1  pixel clock; one clock; also drives the buffer's rdclk
- reset_n  in  1  reset, asynchronous, active-low
- rdaddress  out  ADDR_W  buffer read address
- read_data  in  8  buffer read data (RGB332), valid one clk after rdaddress
- rgb  out  24  {R8,G8,B8} pixel
- de  out  1  data enable, high on visible pixels
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- frame_start  out  1  one-cycle pulse, aligned with pixel (0,0) on rgb/de
- vblank  out  1  stage-0 status: v_cnt >= V_ACTIVE (writers may use it to avoid tearing)

## Operation
- Stage 0: h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1. h_cnt wraps to 0 after H_TOTAL-1; v_cnt increments on h wrap and wraps to 0 after V_TOTAL-1.
- Visible when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync is asserted (0) while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and likewise for v_cnt.
- Address: pix_cnt register drives rdaddress directly, with no multiplier.
  - Holds v_cnt*H_ACTIVE+h_cnt whenever stage 0 is visible.
  - Increments after each visible cycle; holds during blanking.
  - Clears to 0 when stage 0 passes (H_TOTAL-1, V_TOTAL-1), so the next frame starts at 0.
  - Range 0..307199; never exceeds H_ACTIVE*V_ACTIVE-1.
- Stage 1: visible, hs, vs and first-pixel flags are delayed one register to align with read_data.
- Stage 2: output registers.
  - rgb = de1 ? expand(read_data) : 0.
  - de/hsync/vsync/frame_start come from stage-1 flags.
- Expansion:
  - R8 = {d[7:5], d[7:5], d[7:6]}
  - G8 = {d[4:2], d[4:2], d[4:3]}
  - B8 = {d[1:0] x4}
- vblank is combinational from stage-0 v_cnt (not delayed).

## Timing
- Latency: counters at (h,v) -> rdaddress same cycle -> read_data next cycle -> rgb/de/syncs two cycles after stage 0. All outputs share that 2-cycle lag, so sync-to-data alignment is exact.
- Reset (async assert, sync release):
  - h_cnt = v_cnt = 0, pix_cnt = 0, rdaddress = 0
  - rgb = 0, de = 0, hsync = 1, vsync = 1, frame_start = 0
  - All pipeline flags cleared.
  - First clock after release: stage 0 is at (0,0).
  - frame_start first pulses on the 2nd rising edge after release.
- Reset mid-frame abandons the frame. Outputs go to reset values immediately; the restart is a clean frame from (0,0), with no partial line.
- Per frame: exactly 307200 de-high cycles, 525 hsync pulses of 96 cycles, and one vsync pulse of 2 lines (1600 cycles).
- Frame period is 420000 clk.
- read_data during blanking is ignored (rgb forced 0).

## Structure
- Shared package `video_pkg` holds the timing constants (H_*/V_* defaults, H_TOTAL/V_TOTAL derived), ADDR_W, and the RGB332-to-RGB888 expansion function.
- One sub-module, `video_timing`, contains:
  - the h/v counters
  - the visible/hsync/vsync/first-pixel flags at stage 0
  - vblank
- frame_scanout instantiates `video_timing` and adds pix_cnt, the 2-stage alignment pipeline, and expansion.

## Test plan
- Reset, then run one frame with the buffer model returning read_data = addr[7:0] -> de high 307200 cycles; the first visible rgb reflects address 0 and the last reflects 307199; rdaddress never exceeds 307199.
- Constant read_data 0xE0, 0x1C, 0x03, 0x92 -> rgb = 0xFF0000, 0x00FF00, 0x0000FF, 0x9292AA on visible pixels; 0x000000 whenever de = 0.
- Count edges over two frames -> hsync low for 96 clk starting 656 clk after line start; vsync low exactly 1600 clk; frame period 420000 clk; frame_start one pulse per frame coincident with the first de rise.
- Line boundary: at pixel (639,0) -> (0,1), rdaddress goes 639 -> held through 160 blank cycles -> 640.
- Assert reset_n low mid-line (v = 200) for 3 clk -> outputs at reset values asynchronously; after release the next frame starts at rdaddress 0 and frame_start pulses 2 clk after release.
- Frame wrap: from (799,524) -> pix_cnt = 0, vblank drops as v_cnt = 0, no extra de cycle.
